// File: rtl/fetch_pkg.sv
// Shared constants, entry type and helpers for the instruction-fetch stage.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam logic [PC_W-1:0] PC_INC           = 32'd4;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries; flush wins over push, head read from storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       din,
    output fetch_entry_t       dout,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_entry_t     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // The issue rule reserves a slot for every outstanding request.
    always_ff @(posedge clk) begin
        if (!reset && !flush) assert (!(push && full));
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, in-order imem reads, prefetch FIFO toward decode, redirect flush.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects raise fetch_fault and halt issue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  resp_pc;
    logic [PC_W-1:0]  target;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] out_next;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W:0]   inflight;
    logic             halted;
    logic             req_hs;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    fetch_entry_t     din;
    fetch_entry_t     head;

    assign target   = word_align(redirect_pc);
    assign inflight = {1'b0, occupancy} + {1'b0, outstanding};

    assign imem_req_valid = !reset && !halted && !full && (inflight < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_hs         = imem_req_valid && imem_req_ready;

    // Responses owed to flushed requests are counted off by drop.
    assign push = imem_resp_valid && (drop == '0) && !redirect_valid;
    assign pop  = instr_valid && instr_ready;
    assign din  = '{instr: imem_resp_data, pc: resp_pc};

    always_comb begin
        out_next = outstanding;
        if (imem_resp_valid && outstanding != '0) out_next = out_next - 1'b1;
        if (req_hs)                               out_next = out_next + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect_valid) begin
                fetch_pc <= target;
                resp_pc  <= target;
                drop     <= out_next;
            end else begin
                if (req_hs) fetch_pc <= fetch_pc + PC_INC;
                if (push)   resp_pc  <= resp_pc + PC_INC;
                if (imem_resp_valid && drop != '0) drop <= drop - 1'b1;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk) begin
        if (reset)               fault_q <= 1'b0;
        else if (redirect_valid) fault_q <= (redirect_pc[1:0] != 2'b00);
    end

    assign halted      = fault_q;
    assign fetch_fault = fault_q;
`else
    assign halted = 1'b0;
`endif

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    assign instr_valid    = !reset && !empty;
    assign instr          = instr_valid ? head.instr : '0;
    assign instr_pc       = instr_valid ? head.pc : '0;
    assign instr_pc_plus4 = instr_valid ? head.pc + PC_INC : '0;

endmodule
